// File: rtl/the_ffm_pkg.sv
// rtl/the_ffm_pkg.sv - shared constants, types and helpers for the_ffm
package the_ffm_pkg;
    localparam int DEF_BAUD_DIV   = 16;
    localparam int DEF_ORB_DIV    = 25;
    localparam int DEF_REQ_PERIOD = 40000;
    localparam int DEF_REQ_WIDTH  = 16;

    localparam logic [7:0] SYNC_BYTE0 = 8'hAA;
    localparam logic [7:0] SYNC_BYTE1 = 8'h55;

    localparam int FRAME_LEN    = 64;
    localparam int SENSOR_LEN   = 15;
    localparam int NUM_SENSORS  = 4;
    localparam int SENSOR_BYTES = NUM_SENSORS * SENSOR_LEN;

    typedef logic [7:0] byte_t;

    function automatic byte_t sat_inc8(input byte_t v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/the_ffm_uart_rx.sv
// rtl/the_ffm_uart_rx.sv - 8N1 UART receiver with 2-FF input synchroniser
module uart_rx #(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d, ferr_q, ferr_d;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                // a glitch that is high again at mid-bit is not a start
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (sync2_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
endmodule

// File: rtl/the_ffm.sv
// rtl/the_ffm.sv - request strobes, four sensor buffers, MCX accumulator and Orb frame serialiser
module the_ffm
    import the_ffm_pkg::*;
#(
    parameter int BAUD_DIV   = DEF_BAUD_DIV,
    parameter int REQ_PERIOD = DEF_REQ_PERIOD,
    parameter int REQ_WIDTH  = DEF_REQ_WIDTH,
    parameter int ORB_DIV    = DEF_ORB_DIV
) (
    input  logic clk80,
    input  logic rst_n,
    input  logic UART1_RX,
    input  logic UART3_RX,
    input  logic UART4_RX,
    input  logic UART5_RX,
    input  logic UART7_RX,
    output logic UART1_dRX,
    output logic UART3_dRX,
    output logic UART4_dRX,
    output logic UART5_dRX,
    output logic UART7_dRX,
    output logic Orb_serial
);
    localparam int RCW = $clog2(REQ_PERIOD);
    localparam logic [RCW-1:0] REQ_LAST = RCW'(REQ_PERIOD - 1);
    localparam int PWW = $clog2(REQ_WIDTH + 1);
    localparam logic [PWW-1:0] PULSE_LAST = PWW'(REQ_WIDTH - 1);
    localparam int OCW = $clog2(ORB_DIV);
    localparam logic [OCW-1:0] ORB_LAST = OCW'(ORB_DIV - 1);
    localparam logic [3:0] IDX_FULL = 4'(SENSOR_LEN);
    localparam logic [5:0] BYTE_MCX_CNT = 6'(FRAME_LEN - 2);
    localparam logic [5:0] BYTE_MCX_SUM = 6'(FRAME_LEN - 1);

    logic [4:0] rx_line;
    byte_t      rx_data [5];
    logic [4:0] rx_valid, rx_ferr;

    assign rx_line = {UART7_RX, UART5_RX, UART4_RX, UART3_RX, UART1_RX};

    // instances 0..3 are the sensor channels, instance 4 is the MCX line
    for (genvar g = 0; g < 5; g++) begin : g_rx
        uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
            .clk      (clk80),
            .rst_n    (rst_n),
            .rx       (rx_line[g]),
            .data     (rx_data[g]),
            .valid    (rx_valid[g]),
            .frame_err(rx_ferr[g])
        );
    end

    logic [RCW-1:0] req_cnt_q, req_cnt_d;
    logic [PWW-1:0] pulse_q, pulse_d;
    logic           drx_q, drx_d;
    logic           req_wrap;

    logic [3:0] idx_q [NUM_SENSORS];
    logic [3:0] idx_d [NUM_SENSORS];
    byte_t      sens_buf_q [SENSOR_BYTES];
    byte_t      sens_buf_d [SENSOR_BYTES];

    byte_t acc_cnt_q, acc_cnt_d, acc_sum_q, acc_sum_d;
    byte_t mcx_cnt_q, mcx_cnt_d, mcx_sum_q, mcx_sum_d;

    logic [OCW-1:0] orb_div_q, orb_div_d;
    logic [2:0]     orb_bit_q, orb_bit_d;
    logic [5:0]     orb_byte_q, orb_byte_d;
    byte_t          orb_shift_q, orb_shift_d;
    logic           orb_q, orb_d;
    byte_t          frame_byte;

    assign req_wrap = (req_cnt_q == REQ_LAST);

    always_comb begin
        req_cnt_d = req_wrap ? '0 : req_cnt_q + 1'b1;
        drx_d     = req_wrap || (pulse_q != '0);
        if (req_wrap) pulse_d = PULSE_LAST;
        else if (pulse_q != '0) pulse_d = pulse_q - 1'b1;
        else pulse_d = '0;
    end

    always_comb begin
        idx_d      = idx_q;
        sens_buf_d = sens_buf_q;
        for (int c = 0; c < NUM_SENSORS; c++) begin
            if (req_wrap) begin
                idx_d[2'(c)] = '0;
            end else if (rx_valid[3'(c)] && !rx_ferr[3'(c)] && idx_q[2'(c)] != IDX_FULL) begin
                sens_buf_d[6'(c * SENSOR_LEN) + 6'(idx_q[2'(c)])] = rx_data[3'(c)];
                idx_d[2'(c)] = idx_q[2'(c)] + 4'd1;
            end
        end
    end

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        acc_sum_d = acc_sum_q;
        mcx_cnt_d = mcx_cnt_q;
        mcx_sum_d = mcx_sum_q;
        if (req_wrap) begin
            mcx_cnt_d = acc_cnt_q;
            mcx_sum_d = acc_sum_q;
            acc_cnt_d = '0;
            acc_sum_d = '0;
        end else if (rx_valid[4] && !rx_ferr[4]) begin
            acc_cnt_d = sat_inc8(acc_cnt_q);
            acc_sum_d = acc_sum_q + rx_data[4];
        end
    end

    always_comb begin
        if (orb_byte_q == 6'd0) frame_byte = SYNC_BYTE0;
        else if (orb_byte_q == 6'd1) frame_byte = SYNC_BYTE1;
        else if (orb_byte_q == BYTE_MCX_CNT) frame_byte = mcx_cnt_q;
        else if (orb_byte_q == BYTE_MCX_SUM) frame_byte = mcx_sum_q;
        else frame_byte = sens_buf_q[orb_byte_q - 6'd2];
    end

    // the byte is copied into the shifter once, at its first bit, so later buffer writes cannot tear it
    always_comb begin
        orb_div_d   = (orb_div_q == ORB_LAST) ? '0 : orb_div_q + 1'b1;
        orb_bit_d   = orb_bit_q;
        orb_byte_d  = orb_byte_q;
        orb_shift_d = orb_shift_q;
        orb_d       = orb_q;
        if (orb_div_q == '0) begin
            if (orb_bit_q == 3'd0) begin
                orb_d       = frame_byte[7];
                orb_shift_d = {frame_byte[6:0], 1'b0};
            end else begin
                orb_d       = orb_shift_q[7];
                orb_shift_d = {orb_shift_q[6:0], 1'b0};
            end
        end
        if (orb_div_q == ORB_LAST) begin
            orb_bit_d = orb_bit_q + 3'd1;
            if (orb_bit_q == 3'd7) orb_byte_d = orb_byte_q + 6'd1;
        end
    end

    always_ff @(posedge clk80 or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt_q   <= '0;
            pulse_q     <= '0;
            drx_q       <= 1'b0;
            idx_q       <= '{default: '0};
            sens_buf_q  <= '{default: '0};
            acc_cnt_q   <= '0;
            acc_sum_q   <= '0;
            mcx_cnt_q   <= '0;
            mcx_sum_q   <= '0;
            orb_div_q   <= '0;
            orb_bit_q   <= '0;
            orb_byte_q  <= '0;
            orb_shift_q <= '0;
            orb_q       <= 1'b0;
        end else begin
            req_cnt_q   <= req_cnt_d;
            pulse_q     <= pulse_d;
            drx_q       <= drx_d;
            idx_q       <= idx_d;
            sens_buf_q  <= sens_buf_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_sum_q   <= acc_sum_d;
            mcx_cnt_q   <= mcx_cnt_d;
            mcx_sum_q   <= mcx_sum_d;
            orb_div_q   <= orb_div_d;
            orb_bit_q   <= orb_bit_d;
            orb_byte_q  <= orb_byte_d;
            orb_shift_q <= orb_shift_d;
            orb_q       <= orb_d;
        end
    end

    assign UART1_dRX  = drx_q;
    assign UART3_dRX  = drx_q;
    assign UART4_dRX  = drx_q;
    assign UART5_dRX  = drx_q;
    assign UART7_dRX  = drx_q;
    assign Orb_serial = orb_q;
endmodule

// File: tb/tb_the_ffm.sv
// tb/tb_the_ffm.sv - scoreboard bench for the_ffm with shortened period and Orb bit time
module tb_the_ffm;
    localparam int BAUD      = 8;
    localparam int ORB_D     = 4;
    localparam int PERIOD    = 12000;
    localparam int WIDTH     = 16;
    localparam int FRAME_CYC = 64 * 8 * ORB_D;

    typedef struct {
        int         idx;
        logic [7:0] val;
    } exp_t;

    logic clk80 = 1'b0;
    logic rst_n = 1'b0;
    logic rx1 = 1'b1, rx3 = 1'b1, rx4 = 1'b1, rx5 = 1'b1, rx7 = 1'b1;
    logic d1, d3, d4, d5, d7, orb;
    logic [4:0] drx;

    int checks = 0;
    int failures = 0;

    logic [7:0] seq [15] = '{8'd85, 8'd145, 8'd146, 8'd147, 8'd148, 8'd85, 8'd149, 8'd150,
                             8'd151, 8'd152, 8'd85, 8'd153, 8'd154, 8'd155, 8'd156};

    exp_t sens_q[$];
    exp_t hold_q[$];
    exp_t mcx_q[$];
    exp_t frm_q[$];
    int   traffic_done_c;

    the_ffm #(.BAUD_DIV(BAUD), .REQ_PERIOD(PERIOD), .REQ_WIDTH(WIDTH), .ORB_DIV(ORB_D)) dut (
        .clk80     (clk80),
        .rst_n     (rst_n),
        .UART1_RX  (rx1),
        .UART3_RX  (rx3),
        .UART4_RX  (rx4),
        .UART5_RX  (rx5),
        .UART7_RX  (rx7),
        .UART1_dRX (d1),
        .UART3_dRX (d3),
        .UART4_dRX (d4),
        .UART5_dRX (d5),
        .UART7_dRX (d7),
        .Orb_serial(orb)
    );

    assign drx = {d1, d3, d4, d5, d7};

    always #5 clk80 = ~clk80;

    int cyc;
    always @(posedge clk80 or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Orb decoder: bit j occupies cycles 4j..4j+3 after release; sampled one cycle into the bit
    logic [7:0] mon_shift = '0;
    logic [7:0] frame_buf [64];
    logic [7:0] last_frame [64];
    int frame_cnt = 0;
    int cur_start = 0;
    int last_start = -1;
    always @(negedge clk80) begin : mon
        int c, b;
        if (rst_n && cyc >= 1) begin
            c = cyc - 1;
            if (c % ORB_D == 1) begin
                b = c / ORB_D;
                mon_shift = {mon_shift[6:0], orb};
                if (b % 512 == 0) cur_start = c - 1;
                if (b % 8 == 7) begin
                    frame_buf[(b / 8) % 64] = mon_shift;
                    if ((b / 8) % 64 == 63) begin
                        last_frame = frame_buf;
                        last_start = cur_start;
                        frame_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive_line(input int ch, input logic v);
        case (ch)
            0: rx1 = v;
            1: rx3 = v;
            2: rx4 = v;
            3: rx5 = v;
            default: rx7 = v;
        endcase
    endtask

    task automatic send_byte(input int ch, input logic [7:0] b, input logic stop);
        drive_line(ch, 1'b0);
        repeat (BAUD) @(negedge clk80);
        for (int i = 0; i < 8; i++) begin
            drive_line(ch, b[i]);
            repeat (BAUD) @(negedge clk80);
        end
        drive_line(ch, stop);
        repeat (BAUD) @(negedge clk80);
        drive_line(ch, 1'b1);
    endtask

    task automatic send_sensor(input int ch, input bit bad_first);
        int pos;
        exp_t e;
        logic [7:0] b;
        pos = 0;
        if (bad_first) begin
            send_byte(ch, 8'h77, 1'b0);
            repeat (2 * BAUD) @(negedge clk80);
        end
        for (int i = 0; i < 16; i++) begin
            b = (i < 15) ? seq[i] : 8'hEE;
            if (pos < 15) begin
                e.idx = 2 + ch * 15 + pos;
                e.val = b;
                sens_q.push_back(e);
                pos++;
            end
            send_byte(ch, b, 1'b1);
        end
    endtask

    task automatic send_mcx(input int n);
        logic [7:0] s;
        int cnt;
        exp_t e;
        s = 8'd0;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            s = s + seq[i % 15];
            cnt++;
            send_byte(4, seq[i % 15], 1'b1);
        end
        e.idx = 62;
        e.val = (cnt > 255) ? 8'hFF : 8'(cnt);
        mcx_q.push_back(e);
        e.idx = 63;
        e.val = s;
        mcx_q.push_back(e);
    endtask

    task automatic wait_frame(input int after_c, output bit ok);
        int n, budget;
        ok = 1'b0;
        budget = 0;
        while (!ok && budget < 3 * FRAME_CYC) begin
            n = frame_cnt;
            while (frame_cnt == n && budget < 3 * FRAME_CYC) begin
                @(negedge clk80);
                budget++;
            end
            if (frame_cnt != n && last_start >= after_c) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk80);
        checks++;
        if (drx !== 5'b0) begin
            failures++;
            $display("FAIL reset_drx: got %b expected 00000", drx);
        end
        checks++;
        if (orb !== 1'b0) begin
            failures++;
            $display("FAIL reset_orb: got %b expected 0", orb);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sync_bytes;
        bit ok;
        exp_t e;
        for (int k = 0; k < 64; k++) begin
            e.idx = k;
            e.val = (k == 0) ? 8'hAA : (k == 1) ? 8'h55 : 8'h00;
            frm_q.push_back(e);
        end
        wait_frame(0, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL sync_frame_timeout: got no frame expected one");
        end
        while (frm_q.size() > 0) begin
            e = frm_q.pop_front();
            checks++;
            if (last_frame[e.idx] !== e.val) begin
                failures++;
                $display("FAIL sync_byte%0d: got %h expected %h", e.idx, last_frame[e.idx], e.val);
            end
        end
    endtask

    task automatic test_request(input int n);
        int base, budget;
        logic [4:0] exp;
        base = n * PERIOD;
        budget = 0;
        while (cyc != base - 2 && budget < PERIOD + 100) begin
            @(negedge clk80);
            budget++;
        end
        checks++;
        if (cyc != base - 2) begin
            failures++;
            $display("FAIL request%0d_timeout: got cyc %0d expected %0d", n, cyc, base - 2);
        end
        for (int k = -2; k <= WIDTH + 1; k++) begin
            exp = (k >= 0 && k < WIDTH) ? 5'h1F : 5'h00;
            checks++;
            if (drx !== exp) begin
                failures++;
                $display("FAIL request%0d_drx_at%0d: got %b expected %b", n, k, drx, exp);
            end
            @(negedge clk80);
        end
    endtask

    task automatic test_traffic;
        fork
            send_sensor(0, 1'b0);
            send_sensor(1, 1'b1);
            send_sensor(2, 1'b0);
            send_sensor(3, 1'b0);
            send_mcx(144);
        join
        repeat (2 * BAUD) @(negedge clk80);
        traffic_done_c = cyc;
    endtask

    task automatic test_sensor_frame;
        bit ok;
        exp_t e;
        wait_frame(traffic_done_c - 10 * FRAME_CYC, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL sensor_frame_timeout: got no frame expected one");
        end
        while (sens_q.size() > 0) begin
            e = sens_q.pop_front();
            hold_q.push_back(e);
            checks++;
            if (last_frame[e.idx] !== e.val) begin
                failures++;
                $display("FAIL sensor_byte%0d: got %h expected %h", e.idx, last_frame[e.idx], e.val);
            end
        end
    endtask

    task automatic test_mcx_frame;
        bit ok;
        exp_t e;
        wait_frame(2 * PERIOD, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL mcx_frame_timeout: got no frame expected one");
        end
        while (mcx_q.size() > 0) begin
            e = mcx_q.pop_front();
            checks++;
            if (last_frame[e.idx] !== e.val) begin
                failures++;
                $display("FAIL mcx_byte%0d: got %h expected %h", e.idx, last_frame[e.idx], e.val);
            end
        end
        while (hold_q.size() > 0) begin
            e = hold_q.pop_front();
            checks++;
            if (last_frame[e.idx] !== e.val) begin
                failures++;
                $display("FAIL held_byte%0d: got %h expected %h", e.idx, last_frame[e.idx], e.val);
            end
        end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        exp_t e;
        repeat (700) @(negedge clk80);
        fork
            send_byte(0, 8'h3C, 1'b1);
            begin
                repeat (30) @(negedge clk80);
                rst_n = 1'b0;
                @(negedge clk80);
                checks++;
                if (orb !== 1'b0) begin
                    failures++;
                    $display("FAIL midreset_orb: got %b expected 0", orb);
                end
                checks++;
                if (drx !== 5'b0) begin
                    failures++;
                    $display("FAIL midreset_drx: got %b expected 00000", drx);
                end
            end
        join
        repeat (10) @(negedge clk80);
        for (int k = 0; k < 64; k++) begin
            e.idx = k;
            e.val = (k == 0) ? 8'hAA : (k == 1) ? 8'h55 : 8'h00;
            frm_q.push_back(e);
        end
        rst_n = 1'b1;
        wait_frame(0, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midreset_frame_timeout: got no frame expected one");
        end
        while (frm_q.size() > 0) begin
            e = frm_q.pop_front();
            checks++;
            if (last_frame[e.idx] !== e.val) begin
                failures++;
                $display("FAIL midreset_byte%0d: got %h expected %h", e.idx, last_frame[e.idx], e.val);
            end
        end
    endtask

    initial begin
        test_reset;
        test_sync_bytes;
        test_request(1);
        test_traffic;
        test_request(2);
        test_sensor_frame;
        test_mcx_frame;
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
